keyboard_decoder: RTL and testbench

- PS/2 keyboard front end that produces the `keyboard_ready`/`keyboard_data` operation stream consumed by the game-logic block. It returns to idle on the consumer's `keyboard_read_fin`.
- Receives raw PS/2 frames and checks their framing and parity. It then strips break and extended sequences and maps the six game keys to 3-bit operation codes.
- Sits between the board PS/2 pins and `Game_Player`, all in the `clock` domain.

---
 rtl/keyboard_decoder.sv | 159 +++++++++++++++
 tb/tb_keyboard_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_decoder.sv
// PS/2 keyboard front end: synchronises the raw PS/2 lines, assembles and
// checks 11-bit frames, strips break/extended prefixes and posts the six
// game keys as 3-bit operation codes with a ready/read-finished handshake.
module keyboard_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int LOG2_TIMEOUT   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    input  logic       keyboard_read_fin,
    output logic       keyboard_ready,
    output logic [2:0] keyboard_data,
    output logic       frame_error
);

    localparam logic [2:0] OP_W     = 3'b000;
    localparam logic [2:0] OP_A     = 3'b001;
    localparam logic [2:0] OP_S     = 3'b010;
    localparam logic [2:0] OP_D     = 3'b011;
    localparam logic [2:0] OP_SPACE = 3'b100;
    localparam logic [2:0] OP_Z     = 3'b101;
    localparam logic [2:0] OP_NONE  = 3'b110;

    localparam logic [LOG2_TIMEOUT-1:0] TIMEOUT_LAST = LOG2_TIMEOUT'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        EXT,
        EXT_BREAK
    } prefix_state_t;

    prefix_state_t state, next_state;

    logic                    ps2_clock_s1, ps2_clock_s2, ps2_clock_prev;
    logic                    ps2_data_s1, ps2_data_s2;
    logic                    fall_edge;
    logic [3:0]              bit_cnt;
    logic [9:0]              frame_bits;
    logic [LOG2_TIMEOUT-1:0] timeout_cnt;
    logic                    frame_ok;
    logic                    byte_valid;
    logic [7:0]              rx_byte;
    logic                    post;
    logic [2:0]              post_op;

    // Two-flop synchronisers for both PS/2 lines plus a history flop on the clock line
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ps2_clock_s1   <= 1'b1;
            ps2_clock_s2   <= 1'b1;
            ps2_clock_prev <= 1'b1;
            ps2_data_s1    <= 1'b1;
            ps2_data_s2    <= 1'b1;
        end else begin
            ps2_clock_s1   <= ps2_clock;
            ps2_clock_s2   <= ps2_clock_s1;
            ps2_clock_prev <= ps2_clock_s2;
            ps2_data_s1    <= ps2_data;
            ps2_data_s2    <= ps2_data_s1;
        end
    end

    assign fall_edge = ps2_clock_prev & ~ps2_clock_s2;

    // The stop bit is the live sample; start, data and parity are already shifted in
    assign frame_ok = ~frame_bits[0] & ps2_data_s2 & (^frame_bits[9:1]);

    // Frame assembly, validation and the inter-edge watchdog that aborts stalled frames
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt     <= '0;
            frame_bits  <= '0;
            timeout_cnt <= '0;
            byte_valid  <= 1'b0;
            rx_byte     <= '0;
            frame_error <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (fall_edge) begin
                timeout_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= frame_bits[8:1];
                    end else begin
                        frame_error <= 1'b1;
                    end
                end else begin
                    bit_cnt    <= bit_cnt + 4'd1;
                    frame_bits <= {ps2_data_s2, frame_bits[9:1]};
                end
            end else if (bit_cnt != 4'd0) begin
                if (timeout_cnt == TIMEOUT_LAST) begin
                    bit_cnt     <= '0;
                    timeout_cnt <= '0;
                    frame_error <= 1'b1;
                end else begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
            end
        end
    end

    // Prefix state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Prefix decoding: swallow key releases and extended keys, map make codes to ops
    always_comb begin
        next_state = state;
        post       = 1'b0;
        post_op    = OP_NONE;
        if (byte_valid) begin
            case (state)
                IDLE: begin
                    case (rx_byte)
                        8'hF0: next_state = BREAK;
                        8'hE0: next_state = EXT;
                        8'h1D: begin post = 1'b1; post_op = OP_W;     end
                        8'h1C: begin post = 1'b1; post_op = OP_A;     end
                        8'h1B: begin post = 1'b1; post_op = OP_S;     end
                        8'h23: begin post = 1'b1; post_op = OP_D;     end
                        8'h29: begin post = 1'b1; post_op = OP_SPACE; end
                        8'h1A: begin post = 1'b1; post_op = OP_Z;     end
                        default: next_state = IDLE;
                    endcase
                end
                BREAK:     next_state = IDLE;
                EXT:       next_state = (rx_byte == 8'hF0) ? EXT_BREAK : IDLE;
                EXT_BREAK: next_state = IDLE;
                default:   next_state = IDLE;
            endcase
        end
    end

    // Output handshake: a new post always wins over a read, latest op overwrites
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            keyboard_ready <= 1'b0;
            keyboard_data  <= OP_NONE;
        end else if (post) begin
            keyboard_ready <= 1'b1;
            keyboard_data  <= post_op;
        end else if (keyboard_read_fin && keyboard_ready) begin
            keyboard_ready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keyboard_decoder.sv
// Self-checking bench for keyboard_decoder: table of single-frame vectors
// followed by hand-written handshake, timeout and async-reset sequences.
module tb_keyboard_decoder;

    localparam int TB_TIMEOUT = 200;

    logic       clock;
    logic       reset;
    logic       ps2_clock;
    logic       ps2_data;
    logic       keyboard_read_fin;
    logic       keyboard_ready;
    logic [2:0] keyboard_data;
    logic       frame_error;

    int checks;
    int failures;
    int err_total;
    int rdy_falls;
    logic prev_rdy;
    logic rdy_n3, rdy_n4, err_n3;

    typedef struct {
        logic [7:0] code;
        bit         flip_par;
        bit         bad_start;
        bit         bad_stop;
        logic       exp_ready;
        logic [2:0] exp_data;
        int         exp_err;
    } vec_t;

    vec_t vecs[19];

    keyboard_decoder #(
        .TIMEOUT_CYCLES(TB_TIMEOUT),
        .LOG2_TIMEOUT(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ps2_clock(ps2_clock),
        .ps2_data(ps2_data),
        .keyboard_read_fin(keyboard_read_fin),
        .keyboard_ready(keyboard_ready),
        .keyboard_data(keyboard_data),
        .frame_error(frame_error)
    );

    // 100 MHz system clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Running tallies of error-pulse cycles and ready falling transitions
    initial begin
        err_total = 0;
        rdy_falls = 0;
        prev_rdy  = 1'b0;
        forever begin
            @(negedge clock);
            if (frame_error === 1'b1) err_total++;
            if (prev_rdy === 1'b1 && keyboard_ready !== 1'b1) rdy_falls++;
            prev_rdy = keyboard_ready;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: run did not finish, required completion within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sends one PS/2 frame (or its first nbits bits); captures outputs around the post cycle
    task automatic applyStimulus(input logic [7:0] code, input bit flip_par, input bit bad_start,
                                 input bit bad_stop, input int nbits, input bit fin_at_post);
        logic [10:0] bits;
        bits[0]   = bad_start;
        bits[8:1] = code;
        bits[9]   = (~^code) ^ flip_par;
        bits[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            ps2_data = bits[i];
            repeat (3) @(negedge clock);
            ps2_clock = 1'b0;
            if (i == 10) begin
                repeat (3) @(negedge clock);
                rdy_n3 = keyboard_ready;
                err_n3 = frame_error;
                if (fin_at_post) keyboard_read_fin = 1'b1;
                @(negedge clock);
                keyboard_read_fin = 1'b0;
                rdy_n4 = keyboard_ready;
            end else begin
                repeat (4) @(negedge clock);
            end
            ps2_clock = 1'b1;
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic readPulse();
        @(negedge clock);
        keyboard_read_fin = 1'b1;
        @(negedge clock);
        keyboard_read_fin = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int err_base;
        int fall_base;
        checks            = 0;
        failures          = 0;
        reset             = 1'b0;
        ps2_clock         = 1'b1;
        ps2_data          = 1'b1;
        keyboard_read_fin = 1'b0;

        vecs[0]  = '{8'h1D, 0, 0, 0, 1'b1, 3'b000, 0};
        vecs[1]  = '{8'hF0, 0, 0, 0, 1'b0, 3'b000, 0};
        vecs[2]  = '{8'h1D, 0, 0, 0, 1'b0, 3'b000, 0};
        vecs[3]  = '{8'h1C, 0, 0, 0, 1'b1, 3'b001, 0};
        vecs[4]  = '{8'h29, 1, 0, 0, 1'b0, 3'b001, 1};
        vecs[5]  = '{8'h29, 0, 0, 0, 1'b1, 3'b100, 0};
        vecs[6]  = '{8'hE0, 0, 0, 0, 1'b0, 3'b100, 0};
        vecs[7]  = '{8'h1D, 0, 0, 0, 1'b0, 3'b100, 0};
        vecs[8]  = '{8'hE0, 0, 0, 0, 1'b0, 3'b100, 0};
        vecs[9]  = '{8'hF0, 0, 0, 0, 1'b0, 3'b100, 0};
        vecs[10] = '{8'h1D, 0, 0, 0, 1'b0, 3'b100, 0};
        vecs[11] = '{8'h1A, 0, 0, 0, 1'b1, 3'b101, 0};
        vecs[12] = '{8'hF0, 0, 0, 0, 1'b0, 3'b101, 0};
        vecs[13] = '{8'h1D, 0, 0, 1, 1'b0, 3'b101, 1};
        vecs[14] = '{8'h1D, 0, 0, 0, 1'b0, 3'b101, 0};
        vecs[15] = '{8'h23, 0, 1, 0, 1'b0, 3'b101, 1};
        vecs[16] = '{8'h29, 0, 0, 0, 1'b1, 3'b100, 0};
        vecs[17] = '{8'h77, 0, 0, 0, 1'b0, 3'b100, 0};
        vecs[18] = '{8'h1B, 0, 0, 0, 1'b1, 3'b010, 0};

        repeat (3) @(negedge clock);
        checkOutput("reset_ready", {31'b0, keyboard_ready}, 32'd0);
        checkOutput("reset_data", {29'b0, keyboard_data}, 32'd6);
        checkOutput("reset_error", {31'b0, frame_error}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        $display("[TB] table vectors");
        for (int v = 0; v < 19; v++) begin
            readPulse();
            err_base = err_total;
            applyStimulus(vecs[v].code, vecs[v].flip_par, vecs[v].bad_start, vecs[v].bad_stop, 11, 0);
            checkOutput($sformatf("vec%0d_ready", v), {31'b0, keyboard_ready}, {31'b0, vecs[v].exp_ready});
            checkOutput($sformatf("vec%0d_data", v), {29'b0, keyboard_data}, {29'b0, vecs[v].exp_data});
            checkOutput($sformatf("vec%0d_err_cycles", v), err_total - err_base, vecs[v].exp_err);
            if (vecs[v].exp_err != 0)
                checkOutput($sformatf("vec%0d_err_latency", v), {31'b0, err_n3}, 32'd1);
        end

        $display("[TB] W latency, hold and read");
        readPulse();
        applyStimulus(8'h1D, 0, 0, 0, 11, 0);
        checkOutput("w_ready_before_n2", {31'b0, rdy_n3}, 32'd0);
        checkOutput("w_ready_at_n2", {31'b0, rdy_n4}, 32'd1);
        checkOutput("w_data", {29'b0, keyboard_data}, 32'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checkOutput($sformatf("w_hold%0d", c), {31'b0, keyboard_ready}, 32'd1);
        end
        @(negedge clock);
        keyboard_read_fin = 1'b1;
        @(negedge clock);
        keyboard_read_fin = 1'b0;
        checkOutput("w_read_ready", {31'b0, keyboard_ready}, 32'd0);
        checkOutput("w_read_data", {29'b0, keyboard_data}, 32'd0);

        $display("[TB] overwrite and collision");
        applyStimulus(8'h1C, 0, 0, 0, 11, 0);
        checkOutput("ow_first_data", {29'b0, keyboard_data}, 32'd1);
        fall_base = rdy_falls;
        applyStimulus(8'h1B, 0, 0, 0, 11, 0);
        checkOutput("ow_ready", {31'b0, keyboard_ready}, 32'd1);
        checkOutput("ow_no_drop", rdy_falls - fall_base, 32'd0);
        checkOutput("ow_data", {29'b0, keyboard_data}, 32'd2);
        applyStimulus(8'h23, 0, 0, 0, 11, 1);
        checkOutput("col_ready_post", {31'b0, rdy_n4}, 32'd1);
        repeat (2) @(negedge clock);
        checkOutput("col_ready", {31'b0, keyboard_ready}, 32'd1);
        checkOutput("col_data", {29'b0, keyboard_data}, 32'd3);

        $display("[TB] timeout recovery");
        readPulse();
        err_base = err_total;
        applyStimulus(8'h1B, 0, 0, 0, 5, 0);
        repeat (TB_TIMEOUT + 60) @(negedge clock);
        checkOutput("to_err_cycles", err_total - err_base, 32'd1);
        checkOutput("to_no_ready", {31'b0, keyboard_ready}, 32'd0);
        applyStimulus(8'h23, 0, 0, 0, 11, 0);
        checkOutput("to_after_ready", {31'b0, keyboard_ready}, 32'd1);
        checkOutput("to_after_data", {29'b0, keyboard_data}, 32'd3);
        checkOutput("to_after_err", err_total - err_base, 32'd1);

        $display("[TB] async reset mid-frame");
        applyStimulus(8'h29, 0, 0, 0, 6, 0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("ar_ready", {31'b0, keyboard_ready}, 32'd0);
        checkOutput("ar_data", {29'b0, keyboard_data}, 32'd6);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        err_base = err_total;
        applyStimulus(8'h1B, 0, 0, 0, 11, 0);
        checkOutput("ar_after_ready", {31'b0, keyboard_ready}, 32'd1);
        checkOutput("ar_after_data", {29'b0, keyboard_data}, 32'd2);
        checkOutput("ar_after_err", err_total - err_base, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
